// File: rtl/lca_arb_pkg.sv
// Shared types, constants and index helpers for the shared-port scheduler.
package lca_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } sched_state_e;

  localparam int MAX_REQUESTS = 16;
  localparam int MAX_IDX_W    = $clog2(MAX_REQUESTS);

  // Increment an index modulo n. n need not be a power of two, so the wrap
  // is an explicit compare against n-1 rather than a bit-width overflow.
  function automatic logic [MAX_IDX_W-1:0] wrap_inc(
    input logic [MAX_IDX_W-1:0] idx,
    input int                   n
  );
    logic [MAX_IDX_W-1:0] res;
    if (int'(idx) == (n - 32'sd1)) begin
      res = {MAX_IDX_W{1'b0}};
    end else begin
      res = idx + {{(MAX_IDX_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/shared_port_scheduler_if.sv
// Requester-side and memory-side handshake bundle of the shared-port scheduler.
interface shared_port_scheduler_if #(
  parameter int NUM_REQUESTS = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
);

  // requester side
  logic [NUM_REQUESTS-1:0]        req_valid;
  logic [NUM_REQUESTS-1:0]        req_ready;
  logic [NUM_REQUESTS*ADDR_W-1:0] req_addr;
  logic [NUM_REQUESTS-1:0]        req_we;
  logic [NUM_REQUESTS*DATA_W-1:0] req_wdata;
  logic [NUM_REQUESTS-1:0]        rsp_valid;
  logic [DATA_W-1:0]              rsp_rdata;

  // memory side
  logic                           mem_valid;
  logic                           mem_ready;
  logic [ADDR_W-1:0]              mem_addr;
  logic                           mem_we;
  logic [DATA_W-1:0]              mem_wdata;
  logic                           mem_rsp_valid;
  logic [DATA_W-1:0]              mem_rsp_rdata;

  // The scheduler itself.
  modport slave (
    input  req_valid, req_addr, req_we, req_wdata,
    input  mem_ready, mem_rsp_valid, mem_rsp_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_valid, mem_addr, mem_we, mem_wdata
  );

  // The environment: requesters plus the memory port.
  modport master (
    output req_valid, req_addr, req_we, req_wdata,
    output mem_ready, mem_rsp_valid, mem_rsp_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_valid, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/rr_select.sv
// Combinational rotating-priority selector: first set request at or after
// ptr, wrapping to the lowest set request when nothing at/after ptr is set.
module rr_select
  import lca_arb_pkg::*;
#(
  parameter  int NUM_REQUESTS = 4,
  localparam int IDX_W        = $clog2(NUM_REQUESTS)
) (
  input  logic [NUM_REQUESTS-1:0] req,
  input  logic [IDX_W-1:0]        ptr,
  output logic [IDX_W-1:0]        winner,
  output logic                    any_valid
);

  logic [NUM_REQUESTS-1:0] masked_s;
  logic                    hit_hi_s;
  logic [IDX_W-1:0]        win_hi_s;
  logic [IDX_W-1:0]        win_lo_s;

  // Keep only requests at or above the priority pointer.
  always_comb begin
    masked_s = '0;
    for (int i = 0; i < NUM_REQUESTS; i++) begin
      masked_s[i] = req[i] & (i >= int'(ptr));
    end
  end

  // Lowest-index pick in the masked and unmasked vectors (descending scan so
  // the lowest set index is the last one written).
  always_comb begin
    hit_hi_s = 1'b0;
    win_hi_s = '0;
    win_lo_s = '0;
    for (int i = NUM_REQUESTS - 1; i >= 0; i--) begin
      hit_hi_s = hit_hi_s | masked_s[i];
      win_hi_s = masked_s[i] ? IDX_W'(i) : win_hi_s;
      win_lo_s = req[i]      ? IDX_W'(i) : win_lo_s;
    end
  end

  assign winner    = hit_hi_s ? win_hi_s : win_lo_s;
  assign any_valid = |req;

endmodule

// File: rtl/shared_port_scheduler.sv
// Round-robin scheduler sharing one single-outstanding memory port between
// NUM_REQUESTS requesters. A transaction owns the port from acceptance until
// its response; the response is steered back to the owner.
module shared_port_scheduler
  import lca_arb_pkg::*;
#(
  parameter  int NUM_REQUESTS = 4,
  parameter  int ADDR_W       = 32,
  parameter  int DATA_W       = 32,
  localparam int IDX_W        = $clog2(NUM_REQUESTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  shared_port_scheduler_if.slave  bus,
  output logic                    busy,
  output logic [IDX_W-1:0]        owner,
  output logic                    err_spurious
);

  sched_state_e            state_r, state_n;
  logic [IDX_W-1:0]        ptr_r, ptr_n;
  logic [IDX_W-1:0]        owner_r, owner_n;
  logic [ADDR_W-1:0]       addr_r, addr_n;
  logic                    we_r, we_n;
  logic [DATA_W-1:0]       wdata_r, wdata_n;

  logic [IDX_W-1:0]        winner_s;
  logic                    any_valid_s;
  logic [IDX_W-1:0]        done_ptr_s;
  logic [NUM_REQUESTS-1:0] req_ready_s;
  logic [NUM_REQUESTS-1:0] rsp_valid_s;
  logic [DATA_W-1:0]       rsp_rdata_s;
  logic                    err_s;

  rr_select #(
    .NUM_REQUESTS (NUM_REQUESTS)
  ) u_rr_select (
    .req       (bus.req_valid),
    .ptr       (ptr_r),
    .winner    (winner_s),
    .any_valid (any_valid_s)
  );

  // Pointer value after completion: slot following the owner, mod N.
  assign done_ptr_s = IDX_W'(wrap_inc(MAX_IDX_W'(owner_r), NUM_REQUESTS));

  // Next-state, capture and response-steering logic.
  always_comb begin
    state_n     = state_r;
    ptr_n       = ptr_r;
    owner_n     = owner_r;
    addr_n      = addr_r;
    we_n        = we_r;
    wdata_n     = wdata_r;
    req_ready_s = '0;
    rsp_valid_s = '0;
    rsp_rdata_s = '0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        err_s = bus.mem_rsp_valid;
        if (any_valid_s) begin
          req_ready_s[winner_s] = 1'b1;
          owner_n = winner_s;
          addr_n  = bus.req_addr[int'(winner_s)*ADDR_W +: ADDR_W];
          we_n    = bus.req_we[winner_s];
          wdata_n = bus.req_wdata[int'(winner_s)*DATA_W +: DATA_W];
          state_n = ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          if (bus.mem_rsp_valid) begin
            rsp_valid_s[owner_r] = 1'b1;
            rsp_rdata_s          = bus.mem_rsp_rdata;
            ptr_n                = done_ptr_s;
            state_n              = IDLE;
          end else begin
            state_n = WAIT_RESP;
          end
        end else begin
          err_s   = bus.mem_rsp_valid;
          state_n = ISSUE;
        end
      end
      WAIT_RESP: begin
        if (bus.mem_rsp_valid) begin
          rsp_valid_s[owner_r] = 1'b1;
          rsp_rdata_s          = bus.mem_rsp_rdata;
          ptr_n                = done_ptr_s;
          state_n              = IDLE;
        end else begin
          state_n = WAIT_RESP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, pointer, owner and captured request fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      owner_r <= '0;
      addr_r  <= '0;
      we_r    <= 1'b0;
      wdata_r <= '0;
    end else begin
      state_r <= state_n;
      ptr_r   <= ptr_n;
      owner_r <= owner_n;
      addr_r  <= addr_n;
      we_r    <= we_n;
      wdata_r <= wdata_n;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_rdata = rsp_rdata_s;
  assign bus.mem_valid = (state_r == ISSUE);
  assign bus.mem_addr  = addr_r;
  assign bus.mem_we    = we_r;
  assign bus.mem_wdata = wdata_r;
  assign busy          = (state_r != IDLE);
  assign owner         = owner_r;
  assign err_spurious  = err_s;

endmodule
